count_ctrl: RTL and testbench

Front-panel control stage that sits directly upstream of the 4-bit up-counter and drives its `enable` and `cntby2` inputs. It takes three raw, bouncing push-button inputs and synchronises and debounces each one. It turns clean presses into a run/stop state machine, a single-step pulse and a count-by-2 mode toggle. Both outputs are registered and connect straight to the counter's `enable` and `cntby2` ports on the same `clk`/`nReset`.

---
 rtl/count_ctrl_pkg.sv | 12 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/count_ctrl.sv | 91 +++++++++
 tb/tb_count_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the front-panel count control stage.
package count_ctrl_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    localparam int DB_CYCLES_DEF = 4;
    localparam int CW_DEF        = 8;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: two-flop synchroniser, counter-based debounce and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce
    import count_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic clk,
    input  logic nReset,
    input  logic btn,
    output logic level,
    output logic press
);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability filter on the raw button
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            // stage p1 -> level: only a run of DB_CYCLES disagreeing samples flips level
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            level_d <= level;
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/count_ctrl.sv
// Run/stop FSM, single-step pulse and count-by-2 toggle driving the
// up-counter's enable and cntby2 inputs from three debounced buttons.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic clk,
    input  logic nReset,
    input  logic btn_run,
    input  logic btn_mode,
    input  logic btn_step,
    output logic enable,
    output logic cntby2,
    output logic running
);

    logic        run_press;
    logic        mode_press;
    logic        step_press;
    logic [2:0]  level_unused;

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        enable_next;
    logic        cntby2_next;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db_run (
        .clk    (clk),
        .nReset (nReset),
        .btn    (btn_run),
        .level  (level_unused[0]),
        .press  (run_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db_mode (
        .clk    (clk),
        .nReset (nReset),
        .btn    (btn_mode),
        .level  (level_unused[1]),
        .press  (mode_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_db_step (
        .clk    (clk),
        .nReset (nReset),
        .btn    (btn_step),
        .level  (level_unused[2]),
        .press  (step_press)
    );

    // A run press in STOP takes priority over a simultaneous step press.
    always_comb begin
        state_next  = state;
        enable_next = 1'b0;
        cntby2_next = cntby2 ^ mode_press;
        case (state)
            STOP: begin
                if (run_press) begin
                    state_next = RUN;
                end else if (step_press) begin
                    enable_next = 1'b1;
                end
            end
            RUN: begin
                if (run_press) begin
                    state_next = STOP;
                end
            end
        endcase
        if (state_next == RUN) begin
            enable_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= STOP;
            enable  <= 1'b0;
            cntby2  <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            enable  <= enable_next;
            cntby2  <= cntby2_next;
            running <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: directed front-panel scenarios followed by
// random button activity, checked against a window-based reference model.
module tb_count_ctrl;

    localparam int DB = 4;

    logic clk;
    logic nReset;
    logic btn_run, btn_mode, btn_step;
    logic enable, cntby2, running;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic en;
        logic by2;
        logic run;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: raw-sample history per button (bit 0 = newest sample).
    logic [31:0] hist [3];
    logic [2:0]  m_db;
    logic [2:0]  m_pend;
    logic        m_run, m_mode, m_en;

    count_ctrl #(.DB_CYCLES(DB), .CW(8)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .btn_run  (btn_run),
        .btn_mode (btn_mode),
        .btn_step (btn_step),
        .enable   (enable),
        .cntby2   (cntby2),
        .running  (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) hist[b] = '0;
        m_db   = '0;
        m_pend = '0;
        m_run  = 1'b0;
        m_mode = 1'b0;
        m_en   = 1'b0;
    endtask

    // One clock edge of the model. A level is accepted once the synchronised
    // samples (raw delayed two edges) over the last DB edges all disagree with it;
    // the resulting press acts on the outputs one edge later.
    task automatic model_step(input logic rst_n, input logic [2:0] raw);
        logic [2:0] new_press;
        logic       nxt_run;
        logic       all_diff;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back('{en: 1'b0, by2: 1'b0, run: 1'b0});
            return;
        end
        nxt_run = m_run ^ m_pend[0];
        m_en    = nxt_run || (!m_run && m_pend[2] && !m_pend[0]);
        m_mode  = m_mode ^ m_pend[1];
        m_run   = nxt_run;
        new_press = '0;
        for (int b = 0; b < 3; b++) begin
            hist[b] = {hist[b][30:0], raw[b]};
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++) begin
                if (hist[b][j] == m_db[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_db[b]      = ~m_db[b];
                new_press[b] = m_db[b];
            end
        end
        m_pend = new_press;
        exp_q.push_back('{en: m_en, by2: m_mode, run: m_run});
    endtask

    task automatic tick(input logic rst_n, input logic r, input logic m, input logic s);
        @(negedge clk);
        nReset   = rst_n;
        btn_run  = r;
        btn_mode = m;
        btn_step = s;
        @(posedge clk);
        model_step(rst_n, {s, m, r});
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a new output triple.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_enable",  enable,  e.en);
                chk("sb_cntby2",  cntby2,  e.by2);
                chk("sb_running", running, e.run);
            end
        end
    end

    initial begin
        logic [2:0] rb;
        logic [5:0] bounce;
        nReset   = 1'b0;
        btn_run  = 1'b0;
        btn_mode = 1'b0;
        btn_step = 1'b0;
        model_reset();

        // reset held, then released
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_enable", enable, 1'b0);
        chk("rst_cntby2", cntby2, 1'b0);
        chk("rst_running", running, 1'b0);
        idle(3);
        chk("post_rst_running", running, 1'b0);

        // run press: outputs rise at E0+6
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 5) chk("run_e5_running", running, 1'b0);
            if (i == 6) begin
                chk("run_e6_running", running, 1'b1);
                chk("run_e6_enable", enable, 1'b1);
            end
        end
        idle(12);
        chk("run_held_running", running, 1'b1);

        // second press stops
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 5) chk("stop_e5_enable", enable, 1'b1);
            if (i == 6) begin
                chk("stop_e6_running", running, 1'b0);
                chk("stop_e6_enable", enable, 1'b0);
            end
        end
        idle(12);

        // short pulse rejected
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        idle(12);
        chk("short_running", running, 1'b0);

        // bounce 1,0,1,1,... accepted once the final run of ones is stable
        bounce = 6'b111101;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, (i < 6) ? bounce[i] : 1'b1, 1'b0, 1'b0);
            if (i == 7) chk("bounce_i7_running", running, 1'b0);
            if (i == 8) chk("bounce_i8_running", running, 1'b1);
        end
        idle(12);

        // step while running: enable stays high
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            chk("step_run_enable", enable, 1'b1);
        end
        idle(12);

        // back to STOP
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        idle(12);

        // single step in STOP: one-cycle enable at E0+6
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            if (i == 5) chk("step_i5_enable", enable, 1'b0);
            if (i == 6) chk("step_i6_enable", enable, 1'b1);
            if (i == 7) chk("step_i7_enable", enable, 1'b0);
            chk("step_running", running, 1'b0);
        end
        idle(12);

        // mode toggles 0 -> 1 -> 0
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) begin
                tick(1'b1, 1'b0, 1'b1, 1'b0);
                if (i == 5) chk("mode_i5_cntby2", cntby2, logic'(p));
                if (i == 6) chk("mode_i6_cntby2", cntby2, logic'(p == 0));
            end
            idle(12);
        end

        // run and step together in STOP: run wins
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            if (i == 6) chk("coll_i6_running", running, 1'b1);
            if (i >= 6) chk("coll_enable", enable, 1'b1);
        end
        idle(12);

        // cntby2 = 1 while running, then async reset mid-cycle
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
        idle(12);
        chk("pre_arst_cntby2", cntby2, 1'b1);
        chk("pre_arst_running", running, 1'b1);
        #1;
        nReset = 1'b0;
        #1;
        chk("arst_enable", enable, 1'b0);
        chk("arst_cntby2", cntby2, 1'b0);
        chk("arst_running", running, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        chk("post_arst_running", running, 1'b0);
        chk("post_arst_cntby2", cntby2, 1'b0);

        // random button activity with one mid-stream reset
        rb = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
            end
            tick((i < 1500 || i > 1502) ? 1'b1 : 1'b0, rb[0], rb[1], rb[2]);
        end

        idle(4);
        #5;
        chk("queue_drained", logic'(exp_q.size() == 0), 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
